// File: rtl/sub4s_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings, default
// operand width and a constant clog2 used to size the bit counter.
package sub4s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int W_DEFAULT = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sub4_serial_fs1.sv
// Single-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module fs1 (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub4_serial.sv
// Bit-serial W-bit subtractor, LSB first through one full-subtractor cell,
// with valid/ready handshakes on the operand pair and the W+1 bit result.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// SHIFT | one difference bit per cycle, W cycles
// DONE  | diff held with out_valid until out_ready
module sub4_serial
  import sub4s_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   diff,
  output logic         busy
);

  localparam int CW = clog2(W) + 1;

  state_t        state, state_next;
  logic [W-1:0]  a_sh, b_sh;
  logic          borrow;
  logic [CW-1:0] cnt;
  // Only W-1 bits are kept: the final bit goes straight into diff.
  logic [W-2:0]  res;
  logic [W-1:0]  res_cat;
  logic          d_bit, borrow_next;
  logic          last_bit;

  fs1 u_fs1 (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (borrow),
    .d   (d_bit),
    .bout(borrow_next)
  );

  assign last_bit  = (cnt == CW'(W - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    res_cat    = {d_bit, res};
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      diff   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          a_sh   <= a;
          b_sh   <= b;
          borrow <= 1'b0;
          cnt    <= '0;
          res    <= '0;
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          res    <= res_cat[W-1:1];
          if (last_bit) diff <= {borrow_next, d_bit, res};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub4_serial.sv
// Directed bench for sub4_serial: reset, basic, borrow, backpressure and an
// exhaustive back-to-back sweep with hand-computed expected differences.
module tb_sub4_serial;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] diff;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sub4_serial #(.W(4)) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .busy     (busy)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_in_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  // Accepts one pair, returns latency to out_valid; leaves in_valid low.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv, output int lat);
    a = av;
    b = bv;
    in_valid = 1'b1;
    wait_in_ready("op_in_ready");
    step();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    wait_out_valid("op_out_valid", lat);
  endtask

  initial begin
    int lat;
    int last_acc;
    logic [4:0] e;
    logic [3:0] ai, bi;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    step();
    step();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset during SHIFT discards the operation
    a = 4'd9; b = 4'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("shift1_busy", 32'(busy), 32'd1);
    chk("shift1_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    step();
    do_op(4'd9, 4'd3, lat);
    chk("after_rst_diff", 32'(diff), 32'd6);
    step();

    // Basic: latency and return to IDLE
    out_ready = 1'b1;
    do_op(4'd9, 4'd3, lat);
    chk("basic_latency", 32'(lat), 32'd4);
    chk("basic_diff", 32'(diff), 32'b00110);
    chk("basic_in_ready_done", 32'(in_ready), 32'd0);
    step();
    chk("basic_idle_in_ready", 32'(in_ready), 32'd1);
    chk("basic_idle_out_valid", 32'(out_valid), 32'd0);
    chk("basic_idle_busy", 32'(busy), 32'd0);

    // Borrow / boundary values
    do_op(4'd0, 4'd15, lat);
    chk("borrow_0_15", 32'(diff), 32'b10001);
    step();
    do_op(4'd15, 4'd15, lat);
    chk("borrow_15_15", 32'(diff), 32'b00000);
    step();
    do_op(4'd15, 4'd0, lat);
    chk("borrow_15_0", 32'(diff), 32'b01111);
    step();

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    do_op(4'd5, 4'd7, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 4'(i);
      b = 4'(15 - i);
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_diff", 32'(diff), 32'b11110);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_diff", 32'(diff), 32'b11110);

    // Exhaustive, back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 256; i++) begin
      ai = 4'(i >> 4);
      bi = 4'(i & 15);
      e  = {1'b0, ai} - {1'b0, bi};
      a = ai;
      b = bi;
      wait_in_ready("exh_in_ready");
      if (last_acc >= 0) chk("exh_spacing", 32'(cyc - last_acc), 32'd6);
      last_acc = cyc;
      step();
      wait_out_valid("exh_out_valid", lat);
      chk("exh_diff", 32'(diff), 32'(e));
    end
    in_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
